game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game-flow controller that sits directly downstream of the level blocks. It consumes each level's `win`/`lose` flags and drives the level reset, the active-level select, the lives count and the screen selector used by the VGA mux. It sequences title, play, level-clear, life-lost, game-over and victory phases, with fixed-length banner screens between them and a debounced start button.

## Interface
Parameters:
- NUM_LEVELS, 3, number of levels played in order; level index 0..NUM_LEVELS-1.
- START_LIVES, 3, lives granted at game start; range 1..7.
- BANNER_CYCLES, 50000000, clock cycles each banner screen is held (2 s at 25 MHz).
- LOAD_CYCLES, 4, cycles `level_reset_n` is held low on level entry; minimum 1.
- DEBOUNCE_CYCLES, 250000, cycles the synchronised button must be stable before a press is accepted.

Ports:
- vga_clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- start_button  in  1  raw pushbutton, active-low, asynchronous to `vga_clock`.
- level_win  in  1  win flag from the active level; level-sensitive.
- level_lose  in  1  lose flag (timer expiry) from the active level; level-sensitive.
- level_reset_n  out  1  active-low reset into the level instances.
- level_select  out  $clog2(NUM_LEVELS) (min 1)  index of the active level.
- lives  out  3  remaining lives.
- screen  out  3  current state encoding, consumed by the VGA screen mux.
- banner_active  out  1  high in LEVEL_CLEAR and LIFE_LOST.

## Operation
- States and encoding: TITLE=0, LOAD=1, PLAY=2, LEVEL_CLEAR=3, LIFE_LOST=4, GAME_OVER=5, VICTORY=6. `screen` equals the state register.
- TITLE: on `start_pulse`, set level_select=0 and lives=START_LIVES, then go to LOAD.
- LOAD: `level_reset_n`=0 for exactly LOAD_CYCLES cycles, then go to PLAY.
- PLAY: `level_reset_n`=1. Win/lose are ignored in the first PLAY cycle (guard cycle). From the second cycle onward:
  - `level_win` -> LEVEL_CLEAR.
  - `level_lose` -> LIFE_LOST.
  - If both are high in the same cycle, win takes priority.
- LEVEL_CLEAR: hold for BANNER_CYCLES cycles. Then go to VICTORY if level_select==NUM_LEVELS-1; otherwise increment level_select and go to LOAD.
- LIFE_LOST: hold for BANNER_CYCLES cycles. Then decrement lives. If lives was 1, go to GAME_OVER (lives=0); otherwise go to LOAD with the same level_select.
- GAME_OVER, VICTORY: on `start_pulse`, go to TITLE.
- `level_reset_n` is 0 in every state except PLAY, so the levels are frozen while a banner or menu is shown.
- `start_pulse` outside TITLE, GAME_OVER and VICTORY is discarded; presses are not queued.
- Banner counter: $clog2(BANNER_CYCLES+1) bits, cleared on state entry, saturates with no wrap-around. level_select never exceeds NUM_LEVELS-1. lives never underflows.

## Timing
- Reset values: state TITLE, level_select 0, lives START_LIVES, level_reset_n 0, banner_active 0, screen 0, debouncer idle, `start_pulse` 0.
- Reset asserted mid-operation returns every register to its reset value on the same edge, regardless of state.
- Debouncer latency: 2 synchroniser flops plus DEBOUNCE_CYCLES stable cycles, then a 1-cycle `start_pulse` on the accepted press edge only. Holding the button produces exactly one pulse.
- State transition occurs on the edge after the qualifying input is sampled. All outputs are registered.
- PLAY->LEVEL_CLEAR: `level_reset_n` falls on the same edge that `screen` changes to 3.

## Configuration
- `GAME_SEQUENCER_LIVES_EN` defined: lives are counted as described above.
- Not defined: lives logic is removed, `lives` is tied to 0, and LIFE_LOST always proceeds to GAME_OVER after its banner.

## Structure
- Shared package `game_pkg`: state enum `game_state_t` with the fixed encodings above, and the constants SCREEN_W=3 and LIVES_W=3.
- One sub-module, `button_debouncer`: synchroniser, stability counter and press-edge pulse. Parameterised by DEBOUNCE_CYCLES.

## Test plan
Bench parameters: NUM_LEVELS=2, START_LIVES=2, BANNER_CYCLES=8, LOAD_CYCLES=4, DEBOUNCE_CYCLES=4.
- Reset, then a start press held 10 cycles -> exactly one `start_pulse`; screen 0->1; level_reset_n low for 4 cycles; then screen=2, lives=2, level_select=0.
- PLAY, `level_win` high -> screen=3 and banner_active=1 for 8 cycles; then LOAD with level_select=1. A second win -> VICTORY (screen=6).
- PLAY, `level_lose` twice -> after the first, lives=1 and level_select unchanged; after the second, screen=5 and lives=0. A start press -> screen=0.
- `level_win` and `level_lose` high in the first PLAY cycle -> ignored. Both held into the second cycle -> LEVEL_CLEAR (win priority).
- Reset asserted during LIFE_LOST, banner count 5 -> immediately screen=0, lives=2, level_reset_n=0, banner_active=0.
- Build without `GAME_SEQUENCER_LIVES_EN`, single lose -> lives=0 throughout; LIFE_LOST then GAME_OVER.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
//   game_state_t : phase encoding; the value doubles as the VGA screen code.
//   SCREEN_W     : width of the screen selector.
//   LIVES_W      : width of the lives counter.
package game_pkg;

   localparam int SCREEN_W = 3;
   localparam int LIVES_W  = 3;

   typedef enum logic [SCREEN_W-1:0] {
      ST_TITLE       = 3'd0,
      ST_LOAD        = 3'd1,
      ST_PLAY        = 3'd2,
      ST_LEVEL_CLEAR = 3'd3,
      ST_LIFE_LOST   = 3'd4,
      ST_GAME_OVER   = 3'd5,
      ST_VICTORY     = 3'd6
   } game_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_sequencer_button_debouncer.sv
// button_debouncer: two-flop synchroniser, stability down-counter and
// press-edge pulse for an active-low pushbutton.
//   vga_clock   in  clock
//   reset       in  asynchronous, active-high
//   button_n    in  raw button, active-low, asynchronous
//   press_pulse out one-cycle pulse when a press is accepted
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic vga_clock,
   input  logic reset,
   input  logic button_n,
   output logic press_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             pressed_q, pressed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   // The counter only runs while the synchronised level disagrees with the
   // accepted level; any bounce back reloads it, so acceptance needs
   // DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      sync1_d   = button_n;
      sync2_d   = sync1_q;
      pressed_d = pressed_q;
      cnt_d     = CNT_RELOAD;
      pulse_d   = 1'b0;
      if (~sync2_q != pressed_q) begin
         if (cnt_q == '0) begin
            pressed_d = ~sync2_q;
            pulse_d   = ~sync2_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         pressed_q <= 1'b0;
         cnt_q     <= CNT_RELOAD;
         pulse_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         pressed_q <= pressed_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
      end
   end

   assign press_pulse = pulse_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller downstream of the level blocks.
// Sequences title, level load, play, level-clear / life-lost banners,
// game-over and victory; all outputs registered.
//   vga_clock     in  sole clock
//   reset         in  asynchronous, active-high
//   start_button  in  raw pushbutton, active-low
//   level_win     in  win flag from active level
//   level_lose    in  lose flag from active level
//   level_reset_n out active-low level reset (high only in PLAY)
//   level_select  out active level index
//   lives         out remaining lives
//   screen        out state encoding for the VGA mux
//   banner_active out high in LEVEL_CLEAR and LIFE_LOST
// Build option GAME_SEQUENCER_LIVES_EN: when defined, lives are counted;
// otherwise lives reads 0 and any lost life ends the game.
//
// state       | meaning
// TITLE       | menu, waiting for start press
// LOAD        | level held in reset for LOAD_CYCLES
// PLAY        | level running; first cycle ignores win/lose
// LEVEL_CLEAR | banner, then next level or victory
// LIFE_LOST   | banner, then retry level or game over
// GAME_OVER   | waiting for start press
// VICTORY     | waiting for start press
module game_sequencer
   import game_pkg::*;
#(
   parameter int NUM_LEVELS      = 3,
   parameter int START_LIVES     = 3,
   parameter int BANNER_CYCLES   = 50000000,
   parameter int LOAD_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   localparam int LS_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
   input  logic                vga_clock,
   input  logic                reset,
   input  logic                start_button,
   input  logic                level_win,
   input  logic                level_lose,
   output logic                level_reset_n,
   output logic [LS_W-1:0]     level_select,
   output logic [LIVES_W-1:0]  lives,
   output logic [SCREEN_W-1:0] screen,
   output logic                banner_active
);

   // One counter times both LOAD and the banners; it is cleared on every
   // state entry, which also marks the PLAY guard cycle (count 0).
   localparam int CNT_MAX_I = max_int(BANNER_CYCLES, LOAD_CYCLES);
   localparam int CNT_W     = $clog2(CNT_MAX_I + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(CNT_MAX_I);
   localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [LS_W-1:0]  LAST_LEVEL  = LS_W'(NUM_LEVELS - 1);

   game_state_t      state_q, state_d;
   logic [LS_W-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rst_n_q, rst_n_d;
   logic             banner_q, banner_d;
   logic             start_pulse;

`ifdef GAME_SEQUENCER_LIVES_EN
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
   logic [LIVES_W-1:0] lives_q, lives_d;
`endif

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .vga_clock  (vga_clock),
      .reset      (reset),
      .button_n   (start_button),
      .press_pulse(start_pulse)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef GAME_SEQUENCER_LIVES_EN
      lives_d = lives_q;
`endif
      case (state_q)
         ST_TITLE: begin
            if (start_pulse) begin
               sel_d   = '0;
`ifdef GAME_SEQUENCER_LIVES_EN
               lives_d = LIVES_INIT;
`endif
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (cnt_q >= LOAD_LAST) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (cnt_q != '0) begin
               if (level_win)       state_d = ST_LEVEL_CLEAR;
               else if (level_lose) state_d = ST_LIFE_LOST;
            end
         end
         ST_LEVEL_CLEAR: begin
            if (cnt_q >= BANNER_LAST) begin
               if (sel_q == LAST_LEVEL) begin
                  state_d = ST_VICTORY;
               end else begin
                  sel_d   = sel_q + 1'b1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LIFE_LOST: begin
            if (cnt_q >= BANNER_LAST) begin
`ifdef GAME_SEQUENCER_LIVES_EN
               if (lives_q <= LIVES_W'(1)) begin
                  lives_d = '0;
                  state_d = ST_GAME_OVER;
               end else begin
                  lives_d = lives_q - 1'b1;
                  state_d = ST_LOAD;
               end
`else
               state_d = ST_GAME_OVER;
`endif
            end
         end
         ST_GAME_OVER, ST_VICTORY: begin
            if (start_pulse) state_d = ST_TITLE;
         end
         default: state_d = ST_TITLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
      // Outputs are registered from the next state so they change on the
      // same edge as screen.
      rst_n_d  = (state_d == ST_PLAY);
      banner_d = (state_d == ST_LEVEL_CLEAR) || (state_d == ST_LIFE_LOST);
   end

   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_TITLE;
         sel_q    <= '0;
         cnt_q    <= '0;
         rst_n_q  <= 1'b0;
         banner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         rst_n_q  <= rst_n_d;
         banner_q <= banner_d;
      end
   end

`ifdef GAME_SEQUENCER_LIVES_EN
   always_ff @(posedge vga_clock or posedge reset) begin
      if (reset) lives_q <= LIVES_INIT;
      else       lives_q <= lives_d;
   end
   assign lives = lives_q;
`else
   assign lives = '0;
`endif

   assign level_reset_n = rst_n_q;
   assign level_select  = sel_q;
   assign screen        = state_q;
   assign banner_active = banner_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

   logic       vga_clock = 1'b0;
   logic       reset;
   logic       start_button;
   logic       level_win;
   logic       level_lose;
   logic       level_reset_n;
   logic [0:0] level_select;
   logic [2:0] lives;
   logic [2:0] screen;
   logic       banner_active;

`ifdef GAME_SEQUENCER_LIVES_EN
   localparam logic [2:0] LVS = 3'd2;
`else
   localparam logic [2:0] LVS = 3'd0;
`endif

   game_sequencer #(
      .NUM_LEVELS     (2),
      .START_LIVES    (2),
      .BANNER_CYCLES  (8),
      .LOAD_CYCLES    (4),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .vga_clock    (vga_clock),
      .reset        (reset),
      .start_button (start_button),
      .level_win    (level_win),
      .level_lose   (level_lose),
      .level_reset_n(level_reset_n),
      .level_select (level_select),
      .lives        (lives),
      .screen       (screen),
      .banner_active(banner_active)
   );

   always #5 vga_clock = ~vga_clock;

   typedef struct packed {
      logic [2:0] scr;
      logic [2:0] lv;
      logic       sel;
      logic       rstn;
      logic       ban;
   } exp_t;

   typedef struct {
      logic btn_n;
      logic win;
      logic lose;
      exp_t exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   tests  = 0;
   int   failed = 0;
   int   pulse_cnt = 0;

   always @(posedge vga_clock)
      if (!reset && dut.start_pulse) pulse_cnt++;

   task automatic add(input int n, input logic btn, input logic win, input logic lose,
                      input logic [2:0] scr, input logic [2:0] lv, input logic sel,
                      input logic rstn, input logic ban);
      vec_t v;
      v.btn_n = btn; v.win = win; v.lose = lose;
      v.exp = '{scr: scr, lv: lv, sel: sel, rstn: rstn, ban: ban};
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic check(input string name, input exp_t exp);
      exp_t act;
      act = '{scr: screen, lv: lives, sel: level_select[0], rstn: level_reset_n, ban: banner_active};
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got scr=%0d lives=%0d sel=%0d rstn=%0d ban=%0d, want scr=%0d lives=%0d sel=%0d rstn=%0d ban=%0d",
                  name, act.scr, act.lv, act.sel, act.rstn, act.ban,
                  exp.scr, exp.lv, exp.sel, exp.rstn, exp.ban);
      end
   endtask

   task automatic run_vecs(input string tag);
      exp_t e;
      for (int i = 0; i < vecs.size(); i++) begin
         start_button = vecs[i].btn_n;
         level_win    = vecs[i].win;
         level_lose   = vecs[i].lose;
         sb_q.push_back(vecs[i].exp);
         @(posedge vga_clock);
         #1;
         e = sb_q.pop_front();
         check($sformatf("%s[%0d]", tag, i), e);
      end
      vecs.delete();
   endtask

   // Press held 10 cycles from a menu state into LOAD, ending on the PLAY entry sample.
   task automatic press_start(input logic [2:0] lv_before, input logic sel_before);
      add(6, 0, 0, 0, 3'd0, lv_before, sel_before, 0, 0);
      add(4, 0, 0, 0, 3'd1, LVS, 0, 0, 0);
      add(1, 1, 0, 0, 3'd2, LVS, 0, 1, 0);
   endtask

   // Press held 10 cycles in GAME_OVER/VICTORY, then released and settled in TITLE.
   task automatic press_exit(input logic [2:0] from_scr, input logic [2:0] lv, input logic sel);
      add(6, 0, 0, 0, from_scr, lv, sel, 0, 0);
      add(4, 0, 0, 0, 3'd0, lv, sel, 0, 0);
      add(8, 1, 0, 0, 3'd0, lv, sel, 0, 0);
   endtask

   initial begin
      reset = 1'b1; start_button = 1'b1; level_win = 1'b0; level_lose = 1'b0;
      @(posedge vga_clock); #1;
      check("reset_state", '{scr: 3'd0, lv: LVS, sel: 1'b0, rstn: 1'b0, ban: 1'b0});
      @(posedge vga_clock); #1;
      reset = 1'b0;

      add(3, 1, 0, 0, 3'd0, LVS, 0, 0, 0);
      add(2, 0, 0, 0, 3'd0, LVS, 0, 0, 0);   // 2-cycle glitch: too short to accept
      add(6, 1, 0, 0, 3'd0, LVS, 0, 0, 0);
      // game 1: guard cycle, win priority, level 1 win, victory
      press_start(LVS, 0);
      add(1, 1, 1, 1, 3'd2, LVS, 0, 1, 0);
      add(1, 1, 1, 1, 3'd3, LVS, 0, 0, 1);
      add(7, 1, 0, 0, 3'd3, LVS, 0, 0, 1);
      add(4, 1, 0, 0, 3'd1, LVS, 1, 0, 0);
      add(2, 1, 0, 0, 3'd2, LVS, 1, 1, 0);
      add(1, 1, 1, 0, 3'd3, LVS, 1, 0, 1);
      add(7, 1, 0, 0, 3'd3, LVS, 1, 0, 1);
      add(3, 1, 1, 1, 3'd6, LVS, 1, 0, 0);
      press_exit(3'd6, LVS, 1);
      // game 2: lose until game over
      press_start(LVS, 1);
      add(1, 1, 0, 0, 3'd2, LVS, 0, 1, 0);
      add(1, 1, 0, 1, 3'd4, LVS, 0, 0, 1);
      add(7, 1, 0, 0, 3'd4, LVS, 0, 0, 1);
`ifdef GAME_SEQUENCER_LIVES_EN
      add(4, 1, 0, 0, 3'd1, 3'd1, 0, 0, 0);
      add(2, 1, 0, 0, 3'd2, 3'd1, 0, 1, 0);
      add(1, 1, 0, 1, 3'd4, 3'd1, 0, 0, 1);
      add(7, 1, 0, 0, 3'd4, 3'd1, 0, 0, 1);
`endif
      add(3, 1, 1, 1, 3'd5, 3'd0, 0, 0, 0);
      press_exit(3'd5, 3'd0, 0);
      run_vecs("flow");

      tests++;
      if (pulse_cnt != 4) begin
         failed++;
         $display("FAIL start_pulse_count: got %0d, want 4", pulse_cnt);
      end

      // reset in LIFE_LOST with banner count 5
      press_start(3'd0, 0);
      add(1, 1, 0, 0, 3'd2, LVS, 0, 1, 0);
      add(1, 1, 0, 1, 3'd4, LVS, 0, 0, 1);
      add(5, 1, 0, 0, 3'd4, LVS, 0, 0, 1);
      run_vecs("pre_reset");
      #1 reset = 1'b1;
      #1 check("async_reset", '{scr: 3'd0, lv: LVS, sel: 1'b0, rstn: 1'b0, ban: 1'b0});
      @(posedge vga_clock); #1;
      reset = 1'b0;
      add(4, 1, 0, 0, 3'd0, LVS, 0, 0, 0);
      run_vecs("post_reset");

      tests++;
      if (pulse_cnt != 5) begin
         failed++;
         $display("FAIL start_pulse_total: got %0d, want 5", pulse_cnt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
